cfg_scan_ctrl: RTL and testbench
================================

// Module: cfg_scan_ctrl
// PURPOSE
//  Bitstream loader for the fabric configuration SRAM scan chain. Accepts config words via valid/ready.
//  Serialises them MSB-first onto the chain's scan_in, driving scan_en for exactly CHAIN_LEN cycles.
//  Captures the bits returning on the chain's scan_out as readback words (the old contents).
//  Holds off fabric writes to the SRAM while loading. Sits between the config port and the LUT/routing SRAM chain.
// PARAMETERS
//  CHAIN_LEN   16  total bits in the scan chain (sum of all sram cells on the chain), >=1
//  WORD_WIDTH  8   width of cfg_data / rb_data, >=1
// PORTS
//  clk         in   1           single clock; all state on posedge
//  rst_n       in   1           asynchronous active-low reset
//  start       in   1           begin a load; sampled in IDLE only
//  abort       in   1           synchronous abort; returns to IDLE from any state
//  cfg_data    in   WORD_WIDTH  config word, MSB shifted first
//  cfg_valid   in   1           cfg_data valid
//  cfg_ready   out  1           controller accepts cfg_data this cycle
//  scan_en     out  1           to chain scan_en
//  scan_in     out  1           to chain scan_in (head of chain)
//  scan_out    in   1           from chain scan_out (tail of chain)
//  fabric_hold out  1           high while busy; fabric must gate its sram we with !fabric_hold
//  busy        out  1           state != IDLE
//  done        out  1           one-cycle pulse: full chain loaded
//  aborted     out  1           one-cycle pulse: load abandoned by abort
//  rb_valid    out  1           one-cycle pulse: rb_data holds one word of readback
//  rb_data     out  WORD_WIDTH  readback bits, right-aligned, first-captured bit highest, unused MSBs 0
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; counters and shift regs cleared.
//  States: IDLE -> LOAD -> SHIFT -> (LOAD | DONE) -> IDLE.
//  IDLE: start=1 -> LOAD; total_cnt=0. start while busy is ignored.
//  LOAD: cfg_ready=1 (combinational from state). On cfg_valid&cfg_ready: sh<=cfg_data, bit_cnt<=0, ->SHIFT.
//        Stays in LOAD indefinitely with cfg_valid=0; scan_en=0 in LOAD (chain holds).
//  SHIFT: scan_en=1, scan_in=sh[WORD_WIDTH-1], both decoded from registers (no comb path from inputs).
//        Each cycle: sh<=sh<<1; rb<={rb[W-2:0],scan_out}; bit_cnt++, total_cnt++.
//        Exit when bit_cnt==WORD_WIDTH-1 or total_cnt==CHAIN_LEN-1 (this cycle is the last shift):
//        rb_valid=1 next cycle with rb_data=captured bits; ->DONE if chain complete else ->LOAD.
//  Partial last word: only the remaining CHAIN_LEN mod WORD_WIDTH MSBs of the word are shifted; LSBs dropped.
//  DONE: done=1 for one cycle, ->IDLE. Exactly CHAIN_LEN scan_en cycles per completed load.
//  Latency: best case 1 (start) + ceil(CHAIN_LEN/W) LOAD cycles + CHAIN_LEN SHIFT cycles + 1 DONE.
//  Bit order: first bit shifted ends in chain cell CHAIN_LEN-1; last bit in cell 0.
//  abort (priority over all but reset): ->IDLE next edge; scan_en=0 that cycle onward; aborted pulses
//        iff busy was 1; no done, no rb_valid. Chain is left partially shifted (documented, not repaired).
//  abort and start together in IDLE: abort wins, stay IDLE, no aborted pulse.
//  fabric_hold=busy; asserted from the cycle after start, deasserted the cycle after done.
//  Async reset mid-SHIFT: outputs drop immediately (scan_en=0), chain contents undefined until reload.
//  Widths: total_cnt $clog2(CHAIN_LEN+1) bits, bit_cnt $clog2(WORD_WIDTH+1) bits; no wrap possible.
// STRUCTURE
//  Shared header fpga_cfg_defs.vh: state encodings (CS_IDLE, CS_LOAD, CS_SHIFT, CS_DONE, 2-bit) and
//  default CHAIN_LEN/WORD_WIDTH, also used by the top-level chain assembly.
//  Single module; counters and shift regs inline. No sub-module.
// TESTING (bench: cfg_scan_ctrl + sram ADDR_WIDTH=4 chain, CHAIN_LEN=16, WORD_WIDTH=8)
//  1 Full load: start, words 8'hA5,8'h3C back-to-back -> 16 scan_en cycles, done once, sram_data=16'hA53C.
//  2 Readback: preload chain 16'h1234, load 16'hFFFF -> rb_data 8'h12 then 8'h34, two rb_valid pulses.
//  3 Stalled input: cfg_valid low 5 cycles between words -> scan_en low during gap, final data still correct.
//  4 Partial word: CHAIN_LEN=12, words 8'hAB,8'hCD -> 12 shifts, chain=12'hABC, last rb_data has 4 bits.
//  5 Abort mid-SHIFT at bit 5 -> scan_en 0 next cycle, aborted=1 once, no done; new start loads cleanly.
//  6 Reset mid-SHIFT (rst_n low 1 cycle) -> all outputs 0 immediately, busy=0; start ignored while busy.

Source files
------------

// File: rtl/cfg_scan_ctrl_pkg.sv
// cfg_scan_ctrl_pkg
//   Shared definitions for the configuration scan-chain loader: controller
//   state encoding and the default chain / word geometry. The chain assembly
//   uses the same defaults so that the loader and the chain always agree on
//   length.
package cfg_scan_ctrl_pkg;

  // Controller states (2-bit encoding shared with the chain assembly)
  typedef enum logic [1:0] {
    CS_IDLE  = 2'd0,
    CS_LOAD  = 2'd1,
    CS_SHIFT = 2'd2,
    CS_DONE  = 2'd3
  } cs_state_e;

  // Default geometry: total cells on the chain and config word width
  localparam int DEFAULT_CHAIN_LEN  = 16;
  localparam int DEFAULT_WORD_WIDTH = 8;

endpackage

// File: rtl/cfg_scan_ctrl.sv
// cfg_scan_ctrl
//   Bitstream loader for the fabric configuration SRAM scan chain. Config
//   words arrive over valid/ready and are shifted MSB-first into the chain
//   with scan_en high for exactly CHAIN_LEN cycles per completed load. The
//   bits falling out of the chain tail (the previous contents) are returned
//   as readback words. fabric_hold tells the fabric to gate its own SRAM
//   writes while a load is in progress.
//
// Ports
//   clk          clock, all state on posedge
//   rst_n        asynchronous active-low reset
//   start        begin a load (only honoured while idle)
//   abort        synchronous abort, returns to idle from any state
//   cfg_data     config word, MSB shifted first
//   cfg_valid    cfg_data valid
//   cfg_ready    word accepted this cycle when cfg_valid is high
//   scan_en      chain shift enable
//   scan_in      chain head data
//   scan_out     chain tail data
//   fabric_hold  high while busy; fabric gates its SRAM we with !fabric_hold
//   busy         controller is not idle
//   done         one-cycle pulse when the whole chain has been loaded
//   aborted      one-cycle pulse when a running load was abandoned
//   rb_valid     one-cycle pulse, rb_data holds one readback word
//   rb_data      readback bits, right-aligned, first captured bit highest
module cfg_scan_ctrl
  import cfg_scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN  = DEFAULT_CHAIN_LEN,
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  scan_en,
  output logic                  scan_in,
  input  logic                  scan_out,
  output logic                  fabric_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  rb_valid,
  output logic [WORD_WIDTH-1:0] rb_data
);

  // Counters are sized to hold their terminal value, so they never wrap
  localparam int TW = $clog2(CHAIN_LEN + 1);
  localparam int BW = $clog2(WORD_WIDTH + 1);

  localparam logic [TW-1:0] TOTAL_LAST = TW'(CHAIN_LEN - 1);
  localparam logic [TW-1:0] TOTAL_ONE  = TW'(1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(WORD_WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE    = BW'(1);

  cs_state_e             state_r;
  logic [WORD_WIDTH-1:0] sh_r;
  logic [WORD_WIDTH-1:0] rb_r;
  logic [BW-1:0]         bit_cnt_r;
  logic [TW-1:0]         total_cnt_r;
  logic                  done_r;
  logic                  aborted_r;
  logic                  rb_valid_r;
  logic [WORD_WIDTH-1:0] rb_data_r;

  logic [WORD_WIDTH-1:0] rb_next_s;
  logic                  chain_end_s;
  logic                  last_shift_s;
  logic                  shifting_s;

  // Readback word after capturing this cycle's tail bit into the LSB
  assign rb_next_s    = (rb_r << 1) | WORD_WIDTH'(scan_out);
  // The current shift is the last one of the word or of the whole chain;
  // a partial last word simply leaves its low bits unshifted in sh_r.
  assign chain_end_s  = (total_cnt_r == TOTAL_LAST);
  assign last_shift_s = (bit_cnt_r == BIT_LAST) || chain_end_s;

  // Chain-facing outputs decode the state register only, never an input
  assign shifting_s  = (state_r == CS_SHIFT);
  assign scan_en     = shifting_s;
  assign scan_in     = shifting_s & sh_r[WORD_WIDTH-1];
  assign cfg_ready   = (state_r == CS_LOAD);
  assign busy        = (state_r != CS_IDLE);
  assign fabric_hold = (state_r != CS_IDLE);
  assign done        = done_r;
  assign aborted     = aborted_r;
  assign rb_valid    = rb_valid_r;
  assign rb_data     = rb_data_r;

  // Controller FSM with counters, shift registers and pulse outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= CS_IDLE;
      sh_r        <= '0;
      rb_r        <= '0;
      bit_cnt_r   <= '0;
      total_cnt_r <= '0;
      done_r      <= 1'b0;
      aborted_r   <= 1'b0;
      rb_valid_r  <= 1'b0;
      rb_data_r   <= '0;
    end else begin
      done_r     <= 1'b0;
      aborted_r  <= 1'b0;
      rb_valid_r <= 1'b0;
      if (abort) begin
        // Abort beats everything; only a load in flight reports it
        aborted_r <= (state_r != CS_IDLE);
        state_r   <= CS_IDLE;
      end else begin
        case (state_r)
          CS_IDLE: begin
            if (start) begin
              total_cnt_r <= '0;
              state_r     <= CS_LOAD;
            end else begin
              state_r <= CS_IDLE;
            end
          end
          CS_LOAD: begin
            if (cfg_valid) begin
              sh_r      <= cfg_data;
              rb_r      <= '0;  // keeps readback right-aligned for short words
              bit_cnt_r <= '0;
              state_r   <= CS_SHIFT;
            end else begin
              state_r <= CS_LOAD;
            end
          end
          CS_SHIFT: begin
            sh_r        <= sh_r << 1;
            rb_r        <= rb_next_s;
            bit_cnt_r   <= bit_cnt_r + BIT_ONE;
            total_cnt_r <= total_cnt_r + TOTAL_ONE;
            if (last_shift_s) begin
              rb_valid_r <= 1'b1;
              rb_data_r  <= rb_next_s;
              if (chain_end_s) begin
                done_r  <= 1'b1;
                state_r <= CS_DONE;
              end else begin
                state_r <= CS_LOAD;
              end
            end else begin
              state_r <= CS_SHIFT;
            end
          end
          CS_DONE: begin
            state_r <= CS_IDLE;
          end
          default: begin
            state_r <= CS_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cfg_scan_ctrl.sv
// tb_cfg_scan_ctrl
//   Directed bench for cfg_scan_ctrl. Instance a drives a 16-cell chain model
//   with 8-bit words; instance b drives a 12-cell chain so the last word is
//   partial. Each chain model shifts toward the tail on scan_en and can be
//   preloaded to a known value to exercise readback.
`timescale 1ns/1ps
module tb_cfg_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  logic       start_a, abort_a, cfg_valid_a, cfg_ready_a, scan_en_a, scan_in_a, scan_out_a;
  logic       fabric_hold_a, busy_a, done_a, aborted_a, rb_valid_a;
  logic [7:0] cfg_data_a, rb_data_a;

  logic       start_b, abort_b, cfg_valid_b, cfg_ready_b, scan_en_b, scan_in_b, scan_out_b;
  logic       fabric_hold_b, busy_b, done_b, aborted_b, rb_valid_b;
  logic [7:0] cfg_data_b, rb_data_b;

  cfg_scan_ctrl #(.CHAIN_LEN(16), .WORD_WIDTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .cfg_data(cfg_data_a), .cfg_valid(cfg_valid_a), .cfg_ready(cfg_ready_a),
    .scan_en(scan_en_a), .scan_in(scan_in_a), .scan_out(scan_out_a),
    .fabric_hold(fabric_hold_a), .busy(busy_a), .done(done_a), .aborted(aborted_a),
    .rb_valid(rb_valid_a), .rb_data(rb_data_a)
  );

  cfg_scan_ctrl #(.CHAIN_LEN(12), .WORD_WIDTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .cfg_data(cfg_data_b), .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b),
    .scan_en(scan_en_b), .scan_in(scan_in_b), .scan_out(scan_out_b),
    .fabric_hold(fabric_hold_b), .busy(busy_b), .done(done_b), .aborted(aborted_b),
    .rb_valid(rb_valid_b), .rb_data(rb_data_b)
  );

  // Chain models: scan_in enters cell 0, scan_out is the last cell
  logic [15:0] chain_a, preload_val_a;
  logic [11:0] chain_b, preload_val_b;
  logic        preload_a, preload_b;
  assign scan_out_a = chain_a[15];
  assign scan_out_b = chain_b[11];

  always @(posedge clk) begin
    if (preload_a) chain_a <= preload_val_a;
    else if (scan_en_a) chain_a <= {chain_a[14:0], scan_in_a};
    if (preload_b) chain_b <= preload_val_b;
    else if (scan_en_b) chain_b <= {chain_b[10:0], scan_in_b};
  end

  // Event monitors: shift cycles, pulses and logged readback words
  int cyc = 0;
  int sen_a = 0, done_n_a = 0, rbv_n_a = 0, abt_n_a = 0;
  int sen_b = 0, done_n_b = 0, rbv_n_b = 0;
  logic [7:0] rb_log_a [0:15];
  logic [7:0] rb_log_b [0:15];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (scan_en_a) sen_a <= sen_a + 1;
    if (done_a) done_n_a <= done_n_a + 1;
    if (aborted_a) abt_n_a <= abt_n_a + 1;
    if (rb_valid_a) begin
      rb_log_a[rbv_n_a % 16] <= rb_data_a;
      rbv_n_a <= rbv_n_a + 1;
    end
    if (scan_en_b) sen_b <= sen_b + 1;
    if (done_b) done_n_b <= done_n_b + 1;
    if (rb_valid_b) begin
      rb_log_b[rbv_n_b % 16] <= rb_data_b;
      rbv_n_b <= rbv_n_b + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload_chain_a(input logic [15:0] v);
    preload_val_a = v; preload_a = 1'b1; tick(); preload_a = 1'b0;
  endtask

  task automatic preload_chain_b(input logic [11:0] v);
    preload_val_b = v; preload_b = 1'b1; tick(); preload_b = 1'b0;
  endtask

  task automatic start_load_a();
    start_a = 1'b1; tick(); start_a = 1'b0;
  endtask

  task automatic wait_ready_a();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (cfg_ready_a) begin ok = 1'b1; break; end
      tick();
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL ready_a_timeout got 0 exp 1"); end
  endtask

  task automatic send_a(input logic [7:0] w);
    cfg_data_a = w;
    cfg_valid_a = 1'b1;
    wait_ready_a();
    tick();
    cfg_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] w);
    bit ok = 1'b0;
    cfg_data_b = w;
    cfg_valid_b = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (cfg_ready_b) begin ok = 1'b1; break; end
      tick();
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL ready_b_timeout got 0 exp 1"); end
    tick();
    cfg_valid_b = 1'b0;
  endtask

  task automatic wait_done_a();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done_a) begin ok = 1'b1; break; end
      tick();
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL done_a_timeout got 0 exp 1"); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; cfg_valid_a = 1'b0; cfg_data_a = 8'h00; preload_a = 1'b0;
    start_b = 1'b0; abort_b = 1'b0; cfg_valid_b = 1'b0; cfg_data_b = 8'h00; preload_b = 1'b0;
    preload_val_a = 16'h0000; preload_val_b = 12'h000;
    repeat (3) tick();
    checks++;
    if ({scan_en_a, scan_in_a, cfg_ready_a, fabric_hold_a, busy_a, done_a, aborted_a, rb_valid_a} !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl_a got %b exp 00000000",
        {scan_en_a, scan_in_a, cfg_ready_a, fabric_hold_a, busy_a, done_a, aborted_a, rb_valid_a});
    end
    checks++;
    if (rb_data_a !== 8'h00) begin errors++; $display("FAIL reset_rb_data_a got %h exp 00", rb_data_a); end
    checks++;
    if ({scan_en_b, cfg_ready_b, busy_b, done_b, rb_valid_b} !== 5'b00000) begin
      errors++; $display("FAIL reset_ctrl_b got %b exp 00000", {scan_en_b, cfg_ready_b, busy_b, done_b, rb_valid_b});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_load();
    int s0, d0, r0, t0;
    preload_chain_a(16'h0000);
    s0 = sen_a; d0 = done_n_a; r0 = rbv_n_a;
    start_load_a();
    t0 = cyc;
    checks++;
    if ({busy_a, fabric_hold_a, cfg_ready_a, scan_en_a} !== 4'b1110) begin
      errors++; $display("FAIL full_after_start got %b exp 1110", {busy_a, fabric_hold_a, cfg_ready_a, scan_en_a});
    end
    send_a(8'hA5);
    send_a(8'h3C);
    wait_done_a();
    checks++;
    if (cyc - t0 !== 18) begin errors++; $display("FAIL full_latency got %0d exp 18", cyc - t0); end
    checks++;
    if (fabric_hold_a !== 1'b1) begin errors++; $display("FAIL full_hold_in_done got %b exp 1", fabric_hold_a); end
    tick();
    checks++;
    if ({busy_a, fabric_hold_a, done_a} !== 3'b000) begin
      errors++; $display("FAIL full_idle_after got %b exp 000", {busy_a, fabric_hold_a, done_a});
    end
    checks++;
    if (sen_a - s0 !== 16) begin errors++; $display("FAIL full_scan_cycles got %0d exp 16", sen_a - s0); end
    checks++;
    if (done_n_a - d0 !== 1) begin errors++; $display("FAIL full_done_count got %0d exp 1", done_n_a - d0); end
    checks++;
    if (rbv_n_a - r0 !== 2) begin errors++; $display("FAIL full_rb_count got %0d exp 2", rbv_n_a - r0); end
    checks++;
    if (chain_a !== 16'hA53C) begin errors++; $display("FAIL full_chain got %h exp a53c", chain_a); end
  endtask

  task automatic test_readback();
    int r0;
    preload_chain_a(16'h1234);
    r0 = rbv_n_a;
    start_load_a();
    send_a(8'hFF);
    send_a(8'hFF);
    wait_done_a();
    tick();
    checks++;
    if (rbv_n_a - r0 !== 2) begin errors++; $display("FAIL rb_count got %0d exp 2", rbv_n_a - r0); end
    checks++;
    if (rb_log_a[r0 % 16] !== 8'h12) begin errors++; $display("FAIL rb_word0 got %h exp 12", rb_log_a[r0 % 16]); end
    checks++;
    if (rb_log_a[(r0 + 1) % 16] !== 8'h34) begin
      errors++; $display("FAIL rb_word1 got %h exp 34", rb_log_a[(r0 + 1) % 16]);
    end
    checks++;
    if (chain_a !== 16'hFFFF) begin errors++; $display("FAIL rb_chain got %h exp ffff", chain_a); end
  endtask

  task automatic test_stall();
    int s0, sg;
    preload_chain_a(16'h0000);
    s0 = sen_a;
    start_load_a();
    send_a(8'h5A);
    wait_ready_a();
    sg = sen_a;
    repeat (5) tick();
    checks++;
    if (sen_a - sg !== 0 || scan_en_a !== 1'b0 || cfg_ready_a !== 1'b1) begin
      errors++; $display("FAIL stall_gap got shifts %0d scan_en %b ready %b exp 0 0 1", sen_a - sg, scan_en_a, cfg_ready_a);
    end
    send_a(8'hC3);
    wait_done_a();
    tick();
    checks++;
    if (chain_a !== 16'h5AC3) begin errors++; $display("FAIL stall_chain got %h exp 5ac3", chain_a); end
    checks++;
    if (sen_a - s0 !== 16) begin errors++; $display("FAIL stall_scan_cycles got %0d exp 16", sen_a - s0); end
  endtask

  task automatic test_partial_word();
    int s0, r0, d0;
    bit ok = 1'b0;
    preload_chain_b(12'h5A7);
    s0 = sen_b; r0 = rbv_n_b; d0 = done_n_b;
    start_b = 1'b1; tick(); start_b = 1'b0;
    send_b(8'hAB);
    send_b(8'hCD);
    for (int i = 0; i < 60; i++) begin
      if (done_b) begin ok = 1'b1; break; end
      tick();
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL done_b_timeout got 0 exp 1"); end
    tick();
    checks++;
    if (chain_b !== 12'hABC) begin errors++; $display("FAIL partial_chain got %h exp abc", chain_b); end
    checks++;
    if (sen_b - s0 !== 12) begin errors++; $display("FAIL partial_scan_cycles got %0d exp 12", sen_b - s0); end
    checks++;
    if (rbv_n_b - r0 !== 2 || done_n_b - d0 !== 1) begin
      errors++; $display("FAIL partial_pulses got rb %0d done %0d exp 2 1", rbv_n_b - r0, done_n_b - d0);
    end
    checks++;
    if (rb_log_b[r0 % 16] !== 8'h5A) begin errors++; $display("FAIL partial_rb0 got %h exp 5a", rb_log_b[r0 % 16]); end
    checks++;
    if (rb_log_b[(r0 + 1) % 16] !== 8'h07) begin
      errors++; $display("FAIL partial_rb1 got %h exp 07", rb_log_b[(r0 + 1) % 16]);
    end
  endtask

  task automatic test_abort();
    int s0, d0, r0, a0;
    preload_chain_a(16'h0000);
    a0 = abt_n_a;
    start_load_a();
    send_a(8'h96);
    repeat (5) tick();
    checks++;
    if (scan_en_a !== 1'b1) begin errors++; $display("FAIL abort_pre_scan_en got %b exp 1", scan_en_a); end
    s0 = sen_a; d0 = done_n_a; r0 = rbv_n_a;
    abort_a = 1'b1; tick(); abort_a = 1'b0;
    checks++;
    if ({scan_en_a, busy_a, fabric_hold_a, cfg_ready_a, aborted_a} !== 5'b00001) begin
      errors++; $display("FAIL abort_next got %b exp 00001", {scan_en_a, busy_a, fabric_hold_a, cfg_ready_a, aborted_a});
    end
    repeat (20) tick();
    checks++;
    if (abt_n_a - a0 !== 1) begin errors++; $display("FAIL abort_pulse_count got %0d exp 1", abt_n_a - a0); end
    checks++;
    if (done_n_a - d0 !== 0 || rbv_n_a - r0 !== 0 || sen_a - s0 !== 1) begin
      errors++; $display("FAIL abort_quiet got done %0d rb %0d shifts %0d exp 0 0 1", done_n_a - d0, rbv_n_a - r0, sen_a - s0);
    end
    checks++;
    if (chain_a !== 16'h0025) begin errors++; $display("FAIL abort_chain got %h exp 0025", chain_a); end
    // abort together with start while idle: stays idle, no pulse
    a0 = abt_n_a;
    start_a = 1'b1; abort_a = 1'b1; tick(); start_a = 1'b0; abort_a = 1'b0;
    tick();
    checks++;
    if (busy_a !== 1'b0 || abt_n_a - a0 !== 0) begin
      errors++; $display("FAIL abort_start_idle got busy %b pulses %0d exp 0 0", busy_a, abt_n_a - a0);
    end
    preload_chain_a(16'h0000);
    s0 = sen_a;
    start_load_a();
    send_a(8'h0F);
    send_a(8'hF0);
    wait_done_a();
    tick();
    checks++;
    if (chain_a !== 16'h0FF0 || sen_a - s0 !== 16) begin
      errors++; $display("FAIL abort_reload got %h shifts %0d exp 0ff0 16", chain_a, sen_a - s0);
    end
  endtask

  task automatic test_reset_mid_shift();
    int s0, d0;
    preload_chain_a(16'hBEEF);
    start_load_a();
    send_a(8'h77);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({scan_en_a, scan_in_a, busy_a, fabric_hold_a, cfg_ready_a, done_a, rb_valid_a, aborted_a} !== 8'h00) begin
      errors++; $display("FAIL rst_mid_outputs got %b exp 00000000",
        {scan_en_a, scan_in_a, busy_a, fabric_hold_a, cfg_ready_a, done_a, rb_valid_a, aborted_a});
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy_a); end
    // start pulses while busy must not restart the load
    preload_chain_a(16'h0000);
    s0 = sen_a; d0 = done_n_a;
    start_load_a();
    send_a(8'h81);
    start_a = 1'b1; repeat (3) tick(); start_a = 1'b0;
    send_a(8'h18);
    wait_done_a();
    tick();
    checks++;
    if (chain_a !== 16'h8118 || sen_a - s0 !== 16 || done_n_a - d0 !== 1) begin
      errors++; $display("FAIL start_while_busy got %h shifts %0d done %0d exp 8118 16 1", chain_a, sen_a - s0, done_n_a - d0);
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_readback();
    test_stall();
    test_partial_word();
    test_abort();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule
